// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared defaults and output FIFO entry type for the arbiter dispatcher
package arb_pkg;

  localparam int ARB_VECTOR_IN = 8;
  localparam int ARB_DATA_W    = 64;
  localparam int ARB_PORT_W    = $clog2(ARB_VECTOR_IN);

  typedef struct packed {
    logic [ARB_DATA_W-1:0] data;
    logic [ARB_PORT_W-1:0] port;
  } fifo_entry_t;

endpackage

// File: rtl/dispatch_fifo2.sv
// rtl/dispatch_fifo2.sv - two-entry output FIFO holding payload plus source port index
module dispatch_fifo2
  import arb_pkg::*;
#(
  parameter type entry_t = fifo_entry_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  entry_t     push_entry,
  input  logic       pop,
  output entry_t     head,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  entry_t mem [2];
  logic   wr_ptr;
  logic   rd_ptr;
  logic   do_push;
  logic   do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset: an empty count already hides every stale entry.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/arb_dispatch.sv
// rtl/arb_dispatch.sv - pops the granted requester into a 2-deep FIFO and drives the downstream port
module arb_dispatch
  import arb_pkg::*;
#(
  parameter int VECTOR_IN = ARB_VECTOR_IN,
  parameter int DATA_W    = ARB_DATA_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [VECTOR_IN-1:0]         req_valid,
  input  logic [VECTOR_IN*DATA_W-1:0]  req_data,
  output logic [VECTOR_IN-1:0]         req_ready,
  output logic [VECTOR_IN-1:0]         request_vector,
  input  logic [VECTOR_IN-1:0]         grant,
  output logic                         stall,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(VECTOR_IN)-1:0] out_port,
  input  logic                         out_ready,
  output logic [15:0]                  bubble_cnt,
  output logic                         grant_err
);

  localparam int PORT_W = $clog2(VECTOR_IN);

  fifo_entry_t       push_entry;
  fifo_entry_t       head;
  logic [1:0]        count;
  logic              full;
  logic              empty;
  logic              grant_multi;
  logic              grant_one;
  logic              grant_hit;
  logic              accept;
  logic              bubble;
  logic              pop;
  logic [PORT_W-1:0] grant_idx;

  function automatic logic [PORT_W-1:0] onehot_to_idx(input logic [VECTOR_IN-1:0] oh);
    logic [PORT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < VECTOR_IN; i++) begin
      if (oh[i]) idx = PORT_W'(i);
    end
    return idx;
  endfunction

  always_comb begin
    grant_multi = ($countones(grant) > 1);
    grant_one   = (grant != '0) && !grant_multi;
    grant_hit   = |(grant & req_valid);
    grant_idx   = onehot_to_idx(grant);
    stall       = (count == 2'd2);
    out_valid   = (count != 2'd0);
    // Reset gating keeps the pop strobe low even while the arbiter is still granting.
    accept      = !reset && grant_one && grant_hit && !stall && !full;
    bubble      = grant_one && !grant_hit && !stall;
    req_ready   = accept ? grant : '0;
    request_vector = reset ? '0 : (req_valid & ~req_ready);
    pop         = out_valid && out_ready && !empty;
    push_entry.data = req_data[grant_idx*DATA_W +: DATA_W];
    push_entry.port = grant_idx;
    out_data    = out_valid ? head.data : '0;
    out_port    = out_valid ? head.port : '0;
  end

  dispatch_fifo2 #(
    .entry_t (fifo_entry_t)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= 16'd0;
      grant_err  <= 1'b0;
    end else begin
      if (bubble && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
      if (grant_multi) grant_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_dispatch.sv
// tb/tb_arb_dispatch.sv - directed table, corner sequences and randomized queue-model check of arb_dispatch
module tb_arb_dispatch;

  localparam int N  = 8;
  localparam int DW = 64;
  localparam int PW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    request_vector;
  logic [N-1:0]    grant;
  logic            stall;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [PW-1:0]   out_port;
  logic            out_ready;
  logic [15:0]     bubble_cnt;
  logic            grant_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arb_dispatch #(.VECTOR_IN(N), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .request_vector (request_vector),
    .grant          (grant),
    .stall          (stall),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_port       (out_port),
    .out_ready      (out_ready),
    .bubble_cnt     (bubble_cnt),
    .grant_err      (grant_err)
  );

  typedef struct {
    logic [7:0] rv;
    logic [7:0] g;
    logic       ordy;
    logic [7:0] rr;
    logic       ov;
    int         port;
    logic       st;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    int            p;
  } ent_t;

  vec_t tbl [17];
  ent_t mq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int p);
    return {32'hD00D_0000 + p, 32'hCAFE_0000 + p};
  endfunction

  task automatic load_pattern();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pat(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    grant = '0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // rv, g, ordy | exp req_ready, out_valid, out_port, stall
    tbl[0]  = '{8'h04, 8'h00, 1'b1, 8'h00, 1'b0, 0, 1'b0};
    tbl[1]  = '{8'h04, 8'h04, 1'b1, 8'h04, 1'b0, 0, 1'b0};
    tbl[2]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 2, 1'b0};
    tbl[3]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 0, 1'b0};
    tbl[4]  = '{8'h07, 8'h01, 1'b0, 8'h01, 1'b0, 0, 1'b0};
    tbl[5]  = '{8'h06, 8'h02, 1'b0, 8'h02, 1'b1, 0, 1'b0};
    tbl[6]  = '{8'h04, 8'h04, 1'b0, 8'h00, 1'b1, 0, 1'b1};
    tbl[7]  = '{8'h04, 8'h04, 1'b0, 8'h00, 1'b1, 0, 1'b1};
    tbl[8]  = '{8'h04, 8'h04, 1'b1, 8'h00, 1'b1, 0, 1'b1};
    tbl[9]  = '{8'h04, 8'h04, 1'b0, 8'h04, 1'b1, 1, 1'b0};
    tbl[10] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1, 1'b1};
    tbl[11] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 2, 1'b0};
    tbl[12] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 0, 1'b0};
    tbl[13] = '{8'h08, 8'h08, 1'b1, 8'h08, 1'b0, 0, 1'b0};
    tbl[14] = '{8'h20, 8'h20, 1'b1, 8'h20, 1'b1, 3, 1'b0};
    tbl[15] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 5, 1'b0};
    tbl[16] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 0, 1'b0};

    reset = 1'b1;
    req_valid = '0;
    grant = '0;
    out_ready = 1'b0;
    req_data = '0;
    load_pattern();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_bubble_cnt", bubble_cnt, 0);
    chk("rst_grant_err", grant_err, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed table: single dispatch, back-pressure with stall, push+pop at count 1.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      req_valid = tbl[i].rv;
      grant     = tbl[i].g;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_req_ready", i), req_ready, tbl[i].rr);
      chk($sformatf("tbl%0d_request_vector", i), request_vector, tbl[i].rv & ~tbl[i].rr);
      chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("tbl%0d_stall", i), stall, tbl[i].st);
      if (tbl[i].ov) begin
        chk($sformatf("tbl%0d_out_port", i), out_port, tbl[i].port);
        chk($sformatf("tbl%0d_out_data", i), out_data, pat(tbl[i].port));
      end
    end

    // Bubble: grant on a port that is not valid.
    @(negedge clk);
    req_valid = 8'h00;
    grant = 8'h10;
    out_ready = 1'b1;
    #1;
    chk("bubble_req_ready", req_ready, 0);
    chk("bubble_cnt_before", bubble_cnt, 0);
    @(negedge clk);
    chk("bubble_cnt_one", bubble_cnt, 1);
    chk("bubble_no_push", out_valid, 0);
    for (int i = 0; i < 70000; i++) @(negedge clk);
    chk("bubble_cnt_saturated", bubble_cnt, 16'hFFFF);

    // Multi-hot grant: sticky error, no push.
    grant = 8'h03;
    req_valid = 8'h03;
    #1;
    chk("multi_req_ready", req_ready, 0);
    chk("multi_request_vector", request_vector, 8'h03);
    @(negedge clk);
    grant = 8'h00;
    req_valid = 8'h00;
    #1;
    chk("multi_grant_err", grant_err, 1);
    chk("multi_no_push", out_valid, 0);
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("multi_grant_err_sticky", grant_err, 1);
    chk("bubble_cnt_held", bubble_cnt, 16'hFFFF);

    // Reset mid-transfer with the FIFO full.
    do_reset();
    #1;
    chk("rst2_grant_err", grant_err, 0);
    chk("rst2_bubble_cnt", bubble_cnt, 0);
    req_valid = 8'h03;
    grant = 8'h01;
    out_ready = 1'b0;
    @(negedge clk);
    grant = 8'h02;
    @(negedge clk);
    grant = 8'h00;
    req_valid = 8'h00;
    #1;
    chk("fill_stall", stall, 1);
    chk("fill_out_port", out_port, 0);
    #1;
    reset = 1'b1;
    req_valid = 8'h0F;
    grant = 8'h04;
    out_ready = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_request_vector", request_vector, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_port", out_port, 0);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 8'h00;
    grant = 8'h00;
    #1;
    chk("postrst_out_valid", out_valid, 0);

    // Randomized run against a queue model.
    do_reset();
    begin
      int        nb;
      logic      err;
      logic [7:0] rv, g;
      logic      ordy, hit, acc, bub, est;
      int        ones, idx;
      nb = 0;
      err = 1'b0;
      mq.delete();
      for (int c = 0; c < 2000; c++) begin
        @(negedge clk);
        rv = 8'($urandom);
        case ($urandom_range(0, 63))
          0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11: g = 8'h00;
          63:      g = 8'($urandom) | 8'h81;
          default: g = 8'h01 << $urandom_range(0, 7);
        endcase
        ordy = ($urandom_range(0, 2) != 0);
        for (int w = 0; w < N*DW/32; w++) req_data[w*32 +: 32] = $urandom;
        req_valid = rv;
        grant = g;
        out_ready = ordy;
        #1;
        ones = 0;
        idx = 0;
        for (int i = 0; i < N; i++) if (g[i]) begin ones++; idx = i; end
        est = (mq.size() == 2);
        hit = ((g & rv) != 0);
        acc = (ones == 1) && hit && !est;
        bub = (ones == 1) && !hit && !est;
        chk("rnd_stall", stall, est);
        chk("rnd_out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
          chk("rnd_out_data", out_data, mq[0].d);
          chk("rnd_out_port", out_port, mq[0].p);
        end
        chk("rnd_req_ready", req_ready, acc ? g : 8'h00);
        chk("rnd_request_vector", request_vector, acc ? (rv & ~g) : rv);
        chk("rnd_bubble_cnt", bubble_cnt, nb);
        chk("rnd_grant_err", grant_err, err);
        if (mq.size() != 0 && ordy) void'(mq.pop_front());
        if (acc) mq.push_back('{req_data[idx*DW +: DW], idx});
        if (bub && nb < 65535) nb++;
        if (ones > 1) err = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arb_dispatch.md
ARB_DISPATCH -- requirements
Module: arb_dispatch

Interface
REQ-001 SHALL have parameter VECTOR_IN, default 8, number of requester ports.
REQ-002 SHALL have parameter DATA_W, default 64, payload width per port.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  VECTOR_IN  per-port payload valid.
REQ-006 SHALL have port req_data  input  VECTOR_IN*DATA_W  packed payloads, port i at bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port req_ready  output  VECTOR_IN  per-port pop strobe, at most one bit set.
REQ-008 SHALL have port request_vector  output  VECTOR_IN  request vector driven to the round-robin arbiter.
REQ-009 SHALL have port grant  input  VECTOR_IN  registered one-hot grant returned by the arbiter.
REQ-010 SHALL have port stall  output  1  grant-hold request to the arbiter.
REQ-011 SHALL have ports out_valid  output  1, out_data  output  DATA_W, out_port  output  $clog2(VECTOR_IN)  downstream payload, source index.
REQ-012 SHALL have port out_ready  input  1  downstream accept.
REQ-013 SHALL have ports bubble_cnt  output  16  and grant_err  output  1  debug status.

Function
REQ-014 SHALL contain a 2-entry output FIFO (payload + port index) with a registered occupancy count 0..2.
REQ-015 SHALL drive stall = (count == 2), purely from registered state.
REQ-016 SHALL define accept = (grant != 0) && !stall && |(grant & req_valid).
REQ-017 SHALL on accept assert req_ready = grant in that same cycle and push {req_data[granted], index} into the FIFO; otherwise req_ready = 0.
REQ-018 SHALL drive request_vector = req_valid & ~req_ready (combinational), so a port popped this cycle is not re-requested on stale valid.
REQ-019 SHALL present the FIFO head on out_data/out_port with out_valid = (count != 0); pop on out_valid && out_ready.
REQ-020 SHALL on simultaneous push and pop keep count unchanged and preserve order; push into full FIFO SHALL be impossible by construction (stall).
REQ-021 SHALL give latency: payload accepted in cycle t appears on out_valid at cycle t+1 when FIFO was empty.
REQ-022 SHALL treat grant != 0 with req_valid[granted] = 0 and !stall as a bubble: no push, no pop, bubble_cnt increments, saturating at 16'hFFFF.
REQ-023 SHALL set grant_err sticky when grant has more than one bit set; such a cycle SHALL not accept.
REQ-024 SHALL keep out_data/out_port stable while out_valid && !out_ready.
REQ-025 SHALL ignore grant while stall is high (arbiter holds it); acceptance resumes the first cycle count < 2.

Reset
REQ-026 SHALL on reset clear count, FIFO pointers, bubble_cnt and grant_err immediately, regardless of clk.
REQ-027 SHALL during reset drive out_valid = 0, stall = 0, req_ready = 0, request_vector = 0, out_data = 0, out_port = 0.
REQ-028 SHALL discard FIFO contents on reset mid-transfer; no payload survives reset.

Structure
REQ-029 SHALL take VECTOR_IN/DATA_W defaults and the FIFO entry struct (data, port) from shared package arb_pkg.
REQ-030 SHALL implement the FIFO as sub-module dispatch_fifo2 (2 entries, push/pop/count/full/empty).
REQ-031 SHALL compute the one-hot-to-index encoding and popcount-based grant_err check locally.

Verification
REQ-032 SHALL cover: reset then req_valid=8'h04, grant=8'h04 one cycle later, out_ready=1 -> req_ready=8'h04, out_valid next cycle, out_port=2.
REQ-033 SHALL cover: out_ready=0, three back-to-back grants (ports 0,1,2 valid) -> two pushes, stall=1 after 2nd, port 2 payload held until out_ready=1, output order 0,1,2.
REQ-034 SHALL cover: grant=8'h10 with req_valid[4]=0 -> no req_ready, bubble_cnt increments by 1; 70000 bubbles -> bubble_cnt=16'hFFFF.
REQ-035 SHALL cover: grant=8'h03 -> grant_err=1 and stays 1 until reset, no push.
REQ-036 SHALL cover: FIFO count=1, same-cycle push and pop -> count stays 1, order preserved.
REQ-037 SHALL cover: reset asserted mid-transfer with count=2 -> out_valid=0 and stall=0 immediately, before next clk edge.
